// File: rtl/fix_add_acc.sv
// Multi-lane saturating fixed-point adder with an optional grouped accumulate mode.
// One valid/ready handshake drives all lanes. The result is held until the consumer accepts it.
module fix_add_acc #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LANES   = 4,
  parameter int unsigned ACC_LEN = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic                   in_mode,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_sum,
  output logic [LANES-1:0]       out_ovf,
  output logic                   busy
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned EXT_W = WIDTH + 2;
  localparam logic signed [EXT_W-1:0] MAX_V = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V = {3'b111, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} stateT;

  stateT                        state;
  logic [CNT_W-1:0]             count;
  logic [LANES-1:0][WIDTH-1:0]  acc;
  logic [LANES-1:0]             ovf;
  logic [LANES-1:0][WIDTH-1:0]  firstSum;
  logic [LANES-1:0][WIDTH-1:0]  accSum;
  logic [LANES-1:0]             firstOvf;
  logic [LANES-1:0]             accOvf;
  logic [WIDTH:0]               stage1;
  logic [WIDTH:0]               stage2;
  logic                         beat;
  logic                         groupDone;

  // Returns {saturated, sat(x + y)}; the add is done two bits wider so it cannot wrap.
  function automatic logic [WIDTH:0] satAdd(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
    logic signed [EXT_W-1:0] s;
    s = $signed({{2{x[WIDTH-1]}}, x}) + $signed({{2{y[WIDTH-1]}}, y});
    if (s > MAX_V)      satAdd = {1'b1, MAX_V[WIDTH-1:0]};
    else if (s < MIN_V) satAdd = {1'b1, MIN_V[WIDTH-1:0]};
    else                satAdd = {1'b0, s[WIDTH-1:0]};
  endfunction

  assign beat      = in_valid && in_ready;
  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign out_sum   = acc;
  assign out_ovf   = ovf;
  assign groupDone = ((count + CNT_W'(1)) == CNT_W'(ACC_LEN)) || in_last;

  // Per-lane datapath. The first stage is the operand pair; the second stage folds it into acc.
  always_comb begin
    firstSum = '0;
    firstOvf = '0;
    accSum   = '0;
    accOvf   = '0;
    stage1   = '0;
    stage2   = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      stage1      = satAdd(in_a[k*WIDTH +: WIDTH], in_b[k*WIDTH +: WIDTH]);
      stage2      = satAdd(acc[k], stage1[WIDTH-1:0]);
      firstSum[k] = stage1[WIDTH-1:0];
      firstOvf[k] = stage1[WIDTH];
      accSum[k]   = stage2[WIDTH-1:0];
      accOvf[k]   = stage1[WIDTH] | stage2[WIDTH];
    end
  end

  // Control FSM together with the accumulator and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      acc   <= '0;
      ovf   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (beat) begin
            acc   <= firstSum;
            ovf   <= firstOvf;
            count <= CNT_W'(1);
            state <= (!in_mode || in_last) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc   <= accSum;
            ovf   <= ovf | accOvf;
            count <= count + CNT_W'(1);
            if (groupDone) state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
            count <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
